pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC write enable.
- Resolves four hazard sources by fixed priority: data-memory wait, multi-cycle mult/div occupancy, taken branch/jump, and load-use.
- Sits beside the hazard/forwarding logic in the top-level datapath.

---
 rtl/hazard_pkg.sv | 29 ++
 rtl/hazard_if.sv | 43 ++++
 rtl/sat_counter.sv | 21 ++
 rtl/pipeline_hazard_ctrl.sv | 101 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// Control bundles are packed {pc, ifid en/fl, idex en/fl, exmem en/fl, memwb}.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_en;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN    = 8'b1101_0101;
  localparam ctrl_t CTRL_FREEZE = 8'b0000_0000;
  localparam ctrl_t CTRL_MD     = 8'b0000_0111;
  localparam ctrl_t CTRL_BR     = 8'b1111_1101;
  localparam ctrl_t CTRL_LU     = 8'b0001_1101;

endpackage

// File: rtl/hazard_if.sv
// Hazard sources in, pipeline-register controls out.
// master = datapath side, slave = hazard sequencer.
interface hazard_if;
  logic [4:0] id_rs_i;
  logic [4:0] id_rt_i;
  logic       id_uses_rt_i;
  logic       ex_mem_read_i;
  logic [4:0] ex_rt_i;
  logic       ex_branch_taken_i;
  logic       ex_md_start_i;
  logic       mem_wait_i;
  logic       pc_en_o;
  logic       ifid_en_o;
  logic       ifid_flush_o;
  logic       idex_en_o;
  logic       idex_flush_o;
  logic       exmem_en_o;
  logic       exmem_flush_o;
  logic       memwb_en_o;
  logic       md_busy_o;

  modport master (
    output id_rs_i, id_rt_i, id_uses_rt_i,
    output ex_mem_read_i, ex_rt_i,
    output ex_branch_taken_i, ex_md_start_i,
    output mem_wait_i,
    input  pc_en_o, ifid_en_o, ifid_flush_o,
    input  idex_en_o, idex_flush_o,
    input  exmem_en_o, exmem_flush_o,
    input  memwb_en_o, md_busy_o
  );

  modport slave (
    input  id_rs_i, id_rt_i, id_uses_rt_i,
    input  ex_mem_read_i, ex_rt_i,
    input  ex_branch_taken_i, ex_md_start_i,
    input  mem_wait_i,
    output pc_en_o, ifid_en_o, ifid_flush_o,
    output idex_en_o, idex_flush_o,
    output exmem_en_o, exmem_flush_o,
    output memwb_en_o, md_busy_o
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter, cleared by async active-low reset.
// Updates on the falling edge like the pipeline registers.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (i_inc && (r_cnt != '1))
      r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Priority: mem wait, mult/div, taken branch, load-use.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_CYCLES = 4,
  parameter int CNT_BITS  = 16
) (
  input  logic                clk,
  input  logic                reset,
  hazard_if.slave             hz,
  output logic [CNT_BITS-1:0] stall_cnt_o
);
  localparam bit MD_STALLS = (MD_CYCLES > 1);
  localparam int MD_LD = MD_STALLS ? MD_CYCLES - 2 : 0;
  localparam logic [3:0] MD_LOAD = 4'(MD_LD);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [3:0] r_md_cnt;
  logic [3:0] w_md_cnt_nxt;
  ctrl_t      w_ctrl;
  logic       w_live;
  logic       w_run;
  logic       w_hit;
  logic       w_freeze;
  logic       w_md_act;
  logic       w_md_go;
  logic       w_br;
  logic       w_lu;

  assign w_hit = hz.ex_mem_read_i
              && (hz.ex_rt_i != REG_ZERO)
              && ((hz.id_rs_i == hz.ex_rt_i)
               || (hz.id_uses_rt_i
                && (hz.id_rt_i == hz.ex_rt_i)));

  // Selects are made mutually exclusive here so the decoder is one-hot.
  assign w_live   = reset && !hz.mem_wait_i;
  assign w_run    = w_live && (r_state == RUN);
  assign w_freeze = reset && hz.mem_wait_i;
  assign w_md_act = w_live && (r_state == MD_WAIT);
  assign w_md_go  = w_run && hz.ex_md_start_i
                 && MD_STALLS;
  assign w_br     = w_run && !w_md_go
                 && hz.ex_branch_taken_i;
  assign w_lu     = w_run && !w_md_go
                 && !hz.ex_branch_taken_i && w_hit;

  always_comb begin
    w_ctrl       = CTRL_RUN;
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    unique case (1'b1)
      w_freeze: w_ctrl = CTRL_FREEZE;
      w_md_act: begin
        w_ctrl       = CTRL_MD;
        w_md_cnt_nxt = r_md_cnt - 4'd1;
        if (r_md_cnt == 4'd1)
          w_state_nxt = RUN;
      end
      w_md_go: begin
        w_ctrl = CTRL_MD;
        if (MD_CYCLES > 2) begin
          w_state_nxt  = MD_WAIT;
          w_md_cnt_nxt = MD_LOAD;
        end
      end
      w_br: w_ctrl = CTRL_BR;
      w_lu: w_ctrl = CTRL_LU;
      default: ;
    endcase
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= RUN;
      r_md_cnt <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  sat_counter #(.W(CNT_BITS)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .i_inc (!w_ctrl.pc_en),
    .o_cnt (stall_cnt_o)
  );

  assign hz.pc_en_o       = w_ctrl.pc_en;
  assign hz.ifid_en_o     = w_ctrl.ifid_en;
  assign hz.ifid_flush_o  = w_ctrl.ifid_flush;
  assign hz.idex_en_o     = w_ctrl.idex_en;
  assign hz.idex_flush_o  = w_ctrl.idex_flush;
  assign hz.exmem_en_o    = w_ctrl.exmem_en;
  assign hz.exmem_flush_o = w_ctrl.exmem_flush;
  assign hz.memwb_en_o    = w_ctrl.memwb_en;
  assign hz.md_busy_o     = reset && (r_state == MD_WAIT);
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench against a cycle-level hazard model.
// Two DUTs share stimulus: 16-bit and 4-bit stall counters.
module tb_pipeline_hazard_ctrl;
  localparam int MDC = 4;
  localparam logic [7:0] V_RUN = 8'b1101_0101;
  localparam logic [7:0] V_FRZ = 8'b0000_0000;
  localparam logic [7:0] V_MD  = 8'b0000_0111;
  localparam logic [7:0] V_BR  = 8'b1111_1101;
  localparam logic [7:0] V_LU  = 8'b0001_1101;

  logic clk = 1'b1;
  logic rst_n = 1'b0;
  logic [4:0] b_rs, b_rt, b_ert;
  logic b_urt, b_mr, b_br, b_md, b_mw;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;
  int checks = 0;
  int failures = 0;
  int m_left = 0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  hazard_if hz ();
  hazard_if hz4 ();

  assign hz.id_rs_i = b_rs;
  assign hz.id_rt_i = b_rt;
  assign hz.id_uses_rt_i = b_urt;
  assign hz.ex_mem_read_i = b_mr;
  assign hz.ex_rt_i = b_ert;
  assign hz.ex_branch_taken_i = b_br;
  assign hz.ex_md_start_i = b_md;
  assign hz.mem_wait_i = b_mw;
  assign hz4.id_rs_i = b_rs;
  assign hz4.id_rt_i = b_rt;
  assign hz4.id_uses_rt_i = b_urt;
  assign hz4.ex_mem_read_i = b_mr;
  assign hz4.ex_rt_i = b_ert;
  assign hz4.ex_branch_taken_i = b_br;
  assign hz4.ex_md_start_i = b_md;
  assign hz4.mem_wait_i = b_mw;

  pipeline_hazard_ctrl #(.MD_CYCLES(MDC), .CNT_BITS(16)) dut (
    .clk(clk), .reset(rst_n), .hz(hz), .stall_cnt_o(cnt16)
  );
  pipeline_hazard_ctrl #(.MD_CYCLES(MDC), .CNT_BITS(4)) dut4 (
    .clk(clk), .reset(rst_n), .hz(hz4), .stall_cnt_o(cnt4)
  );

  function automatic logic [7:0] ctl16();
    return {hz.pc_en_o, hz.ifid_en_o, hz.ifid_flush_o,
            hz.idex_en_o, hz.idex_flush_o, hz.exmem_en_o,
            hz.exmem_flush_o, hz.memwb_en_o};
  endfunction

  function automatic logic [7:0] ctl4();
    return {hz4.pc_en_o, hz4.ifid_en_o, hz4.ifid_flush_o,
            hz4.idex_en_o, hz4.idex_flush_o, hz4.exmem_en_o,
            hz4.exmem_flush_o, hz4.memwb_en_o};
  endfunction

  typedef struct {
    logic [7:0] ctrl;
    bit busy;
    bit stall;
    int nleft;
  } dec_t;

  // left = stall cycles still owed to an in-flight mult/div.
  function automatic dec_t decide(int left, bit rn);
    dec_t d;
    bit lu;
    d.nleft = left;
    d.busy = rn && (left > 0);
    d.stall = 1'b0;
    d.ctrl = V_RUN;
    lu = b_mr && (b_ert != 0) &&
         ((b_rs == b_ert) || (b_urt && (b_rt == b_ert)));
    if (!rn) d.ctrl = V_RUN;
    else if (b_mw) begin
      d.ctrl = V_FRZ; d.stall = 1'b1;
    end else if (left > 0) begin
      d.ctrl = V_MD; d.stall = 1'b1; d.nleft = left - 1;
    end else if (b_md && (MDC > 1)) begin
      d.ctrl = V_MD; d.stall = 1'b1; d.nleft = MDC - 2;
    end else if (b_br) d.ctrl = V_BR;
    else if (lu) begin
      d.ctrl = V_LU; d.stall = 1'b1;
    end
    return d;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk or negedge rst_n) begin
    dec_t d;
    if (!rst_n) begin
      m_left = 0;
      m_cnt = 0;
    end else begin
      d = decide(m_left, 1'b1);
      m_left = d.nleft;
      if (d.stall) m_cnt++;
    end
  end

  always @(posedge clk) begin
    dec_t d;
    d = decide(m_left, rst_n);
    chk("ctrl16", int'(ctl16()), int'(d.ctrl));
    chk("ctrl4", int'(ctl4()), int'(d.ctrl));
    chk("busy16", int'(hz.md_busy_o), int'(d.busy));
    chk("busy4", int'(hz4.md_busy_o), int'(d.busy));
    chk("cnt16", int'(cnt16), (m_cnt > 65535) ? 65535 : m_cnt);
    chk("cnt4", int'(cnt4), (m_cnt > 15) ? 15 : m_cnt);
  end

  task automatic idle();
    b_rs = 5'd0; b_rt = 5'd0; b_ert = 5'd0;
    b_urt = 1'b0; b_mr = 1'b0; b_br = 1'b0;
    b_md = 1'b0; b_mw = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    b_mw = 1'b1; b_br = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_ctrl", int'(ctl16()), int'(V_RUN));
    chk("rst_busy", int'(hz.md_busy_o), 0);
    idle();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_cnt", int'(cnt16), 0);
  endtask

  function automatic logic [4:0] pick();
    int k;
    k = $urandom_range(0, 3);
    if (k == 0) return 5'd0;
    if (k == 1) return 5'd8;
    if (k == 2) return 5'd9;
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    int st, bz;
    idle();
    do_reset();

    b_mr = 1'b1; b_ert = 5'd8; b_rs = 5'd8;
    @(posedge clk);
    chk("lu_pc", int'(hz.pc_en_o), 0);
    chk("lu_idexfl", int'(hz.idex_flush_o), 1);
    @(negedge clk); #1;
    idle();
    chk("lu_cnt", int'(cnt16), 1);
    b_mr = 1'b1; b_ert = 5'd0; b_rs = 5'd0;
    @(posedge clk);
    chk("r0_pc", int'(hz.pc_en_o), 1);
    @(negedge clk); #1;
    b_ert = 5'd8; b_rs = 5'd8; b_br = 1'b1;
    @(posedge clk);
    chk("brlu_ctrl", int'(ctl16()), int'(V_BR));
    @(negedge clk); #1;
    idle();
    chk("brlu_cnt", int'(cnt16), 1);

    do_reset();
    st = 0; bz = 0;
    for (int i = 0; i < 6; i++) begin
      b_md = (i == 0);
      @(posedge clk);
      if (!hz.pc_en_o && hz.exmem_flush_o) st++;
      if (hz.md_busy_o) bz++;
      @(negedge clk); #1;
    end
    idle();
    chk("md_stalls", st, 3);
    chk("md_busy", bz, 2);
    chk("md_cnt", int'(cnt16), 3);

    do_reset();
    st = 0;
    for (int i = 0; i < 8; i++) begin
      b_md = (i == 0);
      b_mw = (i == 1) || (i == 2);
      @(posedge clk);
      if (i == 1) chk("mw_frz", int'(ctl16()), 0);
      if (!hz.pc_en_o) st++;
      @(negedge clk); #1;
    end
    idle();
    chk("mw_stalls", st, 5);
    chk("mw_cnt", int'(cnt16), 5);

    do_reset();
    b_md = 1'b1;
    step();
    b_md = 1'b0;
    @(posedge clk);
    chk("mid_busy", int'(hz.md_busy_o), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_ctrl", int'(ctl16()), int'(V_RUN));
    chk("mid_busy0", int'(hz.md_busy_o), 0);
    chk("mid_cnt0", int'(cnt16), 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("post_busy", int'(hz.md_busy_o), 0);
    chk("post_pc", int'(hz.pc_en_o), 1);
    chk("post_cnt", int'(cnt16), 0);

    do_reset();
    b_mw = 1'b1;
    repeat (20) step();
    idle();
    chk("sat4", int'(cnt4), 15);
    chk("sat16", int'(cnt16), 20);

    do_reset();
    for (int i = 0; i < 1500; i++) begin
      b_mw = ($urandom_range(0, 9) == 0);
      b_md = ($urandom_range(0, 11) == 0);
      b_br = ($urandom_range(0, 5) == 0);
      b_mr = ($urandom_range(0, 2) == 0);
      b_urt = 1'($urandom_range(0, 1));
      b_rs = pick(); b_rt = pick(); b_ert = pick();
      step();
    end
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
